sdp_ram_pipe: RTL and testbench
===============================

SDP_RAM_PIPE -- requirements
Module: sdp_ram_pipe

Interface
REQ-001 SHALL have parameter DW, default 512: data width in bits; a multiple of 8 when BYTE_EN=1.
REQ-002 SHALL have parameter DD, default 1024: depth in words; AW = $clog2(DD).
REQ-003 SHALL have parameter RAM_TYPE, default "block": storage style, one of "distributed", "block" or "ultra".
REQ-004 SHALL have parameter BYTE_EN, default 1: 1 = per-byte write strobes; 0 = full-word writes.
REQ-005 SHALL have parameter RD_LATENCY, default 2: read latency in cycles, legal range 1..3.
REQ-006 SHALL have parameter COLLISION, default "read_first": behaviour on a same-address read/write, one of "read_first" or "write_first".
REQ-007 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the whole array after reset.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-010 SHALL have port wea, input, 1 bit: write request, port A.
REQ-011 SHALL have port wstrb, input, DW/8 bits: byte enables for port A; ignored when BYTE_EN=0.
REQ-012 SHALL have port addra, input, AW bits: write address.
REQ-013 SHALL have port dia, input, DW bits: write data.
REQ-014 SHALL have port reb, input, 1 bit: read request, port B.
REQ-015 SHALL have port addrb, input, AW bits: read address.
REQ-016 SHALL have port dob, output, DW bits: read data.
REQ-017 SHALL have port dob_valid, output, 1 bit: one-cycle pulse qualifying dob.
REQ-018 SHALL have port init_busy, output, 1 bit: high while the clear sequence runs; requests are ignored while it is high.

Function
REQ-019 A write with wea=1 and init_busy=0 SHALL update, at the clock edge, the bytes of word addra whose wstrb bit is 1; it SHALL update the whole word when BYTE_EN=0.
REQ-020 A read with reb=1 and init_busy=0 in cycle N SHALL present the word at addrb on dob, with dob_valid=1, in cycle N+RD_LATENCY.
REQ-021 dob_valid SHALL be 1 for exactly one cycle per accepted read; back-to-back reads SHALL give back-to-back valids, one per cycle, in request order.
REQ-022 dob SHALL hold its last value when dob_valid=0.
REQ-023 On a same-cycle write and read to the same address with COLLISION="read_first", the read SHALL return the pre-write contents.
REQ-024 On a same-cycle write and read to the same address with COLLISION="write_first", the read SHALL return the pre-write word with the strobed bytes replaced by dia.
REQ-025 Requests (wea or reb) made while init_busy=1 SHALL be dropped, with no array change and no dob_valid.
REQ-026 The clear FSM SHALL have states IDLE, CLEAR and READY.
REQ-027 In reset the FSM SHALL be in IDLE.
REQ-028 On the first cycle with resetn=1, the FSM SHALL go to CLEAR if CLEAR_ON_RESET=1, otherwise to READY.
REQ-029 CLEAR SHALL write zero to addresses 0..DD-1, one per cycle, using an AW-bit counter; after address DD-1 it SHALL go to READY.
REQ-030 READY SHALL be terminal until the next reset.
REQ-031 init_busy SHALL be 1 in IDLE and CLEAR and 0 in READY; with CLEAR_ON_RESET=1 it SHALL deassert exactly DD+1 cycles after resetn rises.
REQ-032 Illegal RD_LATENCY or COLLISION values SHALL cause an elaboration-time error.

Reset
REQ-033 resetn=0 SHALL drive dob=0, dob_valid=0 and init_busy=1, and SHALL flush all read-pipeline valids.
REQ-034 Reset SHALL NOT alter array contents, except through the clear sequence that follows reset.
REQ-035 Reset asserted mid-CLEAR SHALL abort the sequence; the next deassertion SHALL restart it from address 0.
REQ-036 Reads in flight when reset asserts SHALL produce no dob_valid.

Structure
REQ-037 Package sdp_ram_pkg SHALL hold the FSM state encodings, the COLLISION mode string constants and the legal RD_LATENCY bounds.
REQ-038 Storage SHALL sit in one sub-module, sdp_ram_array, which holds the ram_style-attributed array, the byte-strobed write and a single registered read.
REQ-039 The top level SHALL hold the extra output registers, the valid shift register, the collision merge and the clear FSM.

Verification
REQ-040 Scenario: DD=16, CLEAR_ON_RESET=1; release resetn -> init_busy high for 17 cycles, then 0; reading all 16 addresses returns 0.
REQ-041 Scenario: write 0x..AABBCCDD to addr 3 with wstrb=all, then 0x11 with wstrb=0x1; read addr 3 -> 0x..AABBCC11, with dob_valid exactly RD_LATENCY cycles after reb.
REQ-042 Scenario: RD_LATENCY=1, 2 and 3, with four back-to-back reads of addrs 0..3 -> four consecutive valid cycles, data in order, starting at N+RD_LATENCY.
REQ-043 Scenario: addr 5 holds 0x1; same-cycle write of 0x2 and read of addr 5 -> 0x1 under read_first, 0x2 under write_first.
REQ-044 Scenario: resetn asserted at clear address 7 then released -> clear restarts at 0; init_busy deasserts DD+1 cycles after release.
REQ-045 Scenario: wea/reb pulsed during CLEAR -> no dob_valid, and the target address still reads 0 afterwards.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// Shared definitions for the simple dual-port RAM pipeline.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package sdp_ram_pkg;

  // Clear sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } clr_state_t;

  // Same-address read/write behaviour selectors
  localparam string COLL_READ_FIRST  = "read_first";
  localparam string COLL_WRITE_FIRST = "write_first";

  // Storage style selectors
  localparam string RAM_DIST  = "distributed";
  localparam string RAM_BLOCK = "block";
  localparam string RAM_ULTRA = "ultra";

  // Legal read latency window, in cycles
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/sdp_ram_array.sv
// Storage array: byte-strobed write port, one registered read port.
// Latency: read data appears one cycle after re.
// Backpressure: none; every we/re presented is performed, rdata holds between reads.
module sdp_ram_array
  import sdp_ram_pkg::*;
#(
  parameter int    DW       = 512,
  parameter int    DD       = 1024,
  parameter string RAM_TYPE = "block",
  parameter int    BYTE_EN  = 1,
  localparam int   AW       = $clog2(DD),
  localparam int   NB       = DW / 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [NB-1:0] wstrb,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  if (RAM_TYPE != RAM_DIST && RAM_TYPE != RAM_BLOCK && RAM_TYPE != RAM_ULTRA) begin : g_bad_type
    $error("sdp_ram_array: RAM_TYPE must be distributed, block or ultra");
  end

  if (BYTE_EN != 0 && (DW % 8) != 0) begin : g_bad_dw
    $error("sdp_ram_array: DW must be a multiple of 8 when BYTE_EN=1");
  end

  (* ram_style = RAM_TYPE *) logic [DW-1:0] mem [DD];

  if (BYTE_EN != 0) begin : g_byte_wr
    // Per-byte write: only strobed lanes of the addressed word change
    always_ff @(posedge clk) begin
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb[b]) begin
            mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end else begin : g_word_wr
    // Full-word write; strobes have no meaning in this mode
    always_ff @(posedge clk) begin
      if (we) begin
        mem[waddr] <= wdata;
      end
    end
  end

  // Registered read; holds its value between reads, cleared by reset
  // (the array itself is never touched by reset)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sdp_ram_pipe.sv
// Simple dual-port RAM with post-reset zero fill, collision handling and a read output pipe.
// Latency: dob/dob_valid appear RD_LATENCY (1..3) cycles after an accepted read.
// Backpressure: none; requests are dropped while init_busy is high, never stalled.
module sdp_ram_pipe
  import sdp_ram_pkg::*;
#(
  parameter int    DW             = 512,
  parameter int    DD             = 1024,
  parameter string RAM_TYPE       = "block",
  parameter int    BYTE_EN        = 1,
  parameter int    RD_LATENCY     = 2,
  parameter string COLLISION      = "read_first",
  parameter int    CLEAR_ON_RESET = 1,
  localparam int   AW             = $clog2(DD),
  localparam int   NB             = DW / 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wea,
  input  logic [NB-1:0] wstrb,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dia,
  input  logic          reb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] dob,
  output logic          dob_valid,
  output logic          init_busy
);

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_lat
    $error("sdp_ram_pipe: RD_LATENCY must be within 1..3");
  end

  if (COLLISION != COLL_READ_FIRST && COLLISION != COLL_WRITE_FIRST) begin : g_bad_coll
    $error("sdp_ram_pipe: COLLISION must be read_first or write_first");
  end

  localparam bit WR_FIRST = (COLLISION == COLL_WRITE_FIRST);

  clr_state_t    state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          clr_we;

  logic          wr_acc, rd_acc;
  logic [NB-1:0] strb_eff;
  logic          arr_we;
  logic [NB-1:0] arr_strb;
  logic [AW-1:0] arr_addr;
  logic [DW-1:0] arr_dat;
  logic [DW-1:0] rdata;
  logic [DW-1:0] merged;

  logic [RD_LATENCY-1:0] vld_sr;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------

  // State and address counter; reset always lands in IDLE with the counter at 0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: IDLE lasts one cycle, CLEAR walks every address once, READY is terminal
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr_we   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx   = '0;
        state_nx = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == AW'(DD - 1)) begin
          state_nx = ST_READY;
        end
      end
      ST_READY: begin
        state_nx = ST_READY;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign init_busy = (state != ST_READY);

  // ---------------------------------------------------------------------------
  // Request gating and array port muxing
  // ---------------------------------------------------------------------------

  // Requests count only once READY and outside reset, so a reset edge never writes the array
  assign wr_acc   = wea & ~init_busy & resetn;
  assign rd_acc   = reb & ~init_busy & resetn;
  assign strb_eff = (BYTE_EN != 0) ? wstrb : '1;

  assign arr_we   = (clr_we & resetn) | wr_acc;
  assign arr_addr = clr_we ? cnt : addra;
  assign arr_dat  = clr_we ? '0 : dia;
  assign arr_strb = clr_we ? '1 : strb_eff;

  sdp_ram_array #(
    .DW       (DW),
    .DD       (DD),
    .RAM_TYPE (RAM_TYPE),
    .BYTE_EN  (BYTE_EN)
  ) u_array (
    .clk    (clk),
    .resetn (resetn),
    .we     (arr_we),
    .wstrb  (arr_strb),
    .waddr  (arr_addr),
    .wdata  (arr_dat),
    .re     (rd_acc),
    .raddr  (addrb),
    .rdata  (rdata)
  );

  // ---------------------------------------------------------------------------
  // Collision merge (array read is inherently read-first)
  // ---------------------------------------------------------------------------

  if (WR_FIRST) begin : g_wr_first
    logic          col_q;
    logic [DW-1:0] col_dat;
    logic [NB-1:0] col_strb;
    logic [DW-1:0] col_mask;

    // Remember whether the accepted read hit the same-cycle write, and what was written
    always_ff @(posedge clk) begin
      if (!resetn) begin
        col_q    <= 1'b0;
        col_dat  <= '0;
        col_strb <= '0;
      end else if (rd_acc) begin
        col_q    <= wr_acc && (addra == addrb);
        col_dat  <= dia;
        col_strb <= strb_eff;
      end
    end

    // Overlay the written bytes onto the pre-write word
    always_comb begin
      col_mask = (BYTE_EN != 0) ? '0 : '1;
      if (BYTE_EN != 0) begin
        for (int b = 0; b < NB; b++) begin
          col_mask[b*8 +: 8] = {8{col_strb[b]}};
        end
      end
      merged = col_q ? ((rdata & ~col_mask) | (col_dat & col_mask)) : rdata;
    end
  end else begin : g_rd_first
    assign merged = rdata;
  end

  // ---------------------------------------------------------------------------
  // Read valid pipe and extra output stages
  // ---------------------------------------------------------------------------

  // Bit k marks an accepted read now k+1 cycles old; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= RD_LATENCY'({vld_sr, rd_acc});
    end
  end

  assign dob_valid = vld_sr[RD_LATENCY-1];

  if (RD_LATENCY == 1) begin : g_lat1
    assign dob = merged;
  end else begin : g_latn
    logic [DW-1:0] dstage [RD_LATENCY-1];

    // Each stage loads only when a valid word reaches it, so dob holds between reads
    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int k = 0; k < RD_LATENCY - 1; k++) begin
          dstage[k] <= '0;
        end
      end else begin
        if (vld_sr[0]) begin
          dstage[0] <= merged;
        end
        for (int k = 1; k < RD_LATENCY - 1; k++) begin
          if (vld_sr[k]) begin
            dstage[k] <= dstage[k-1];
          end
        end
      end
    end

    assign dob = dstage[RD_LATENCY-2];
  end

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Randomised and directed bench for sdp_ram_pipe across latencies and collision modes.
// Latency: expected read data is scheduled per instance at issue cycle + RD_LATENCY.
// Backpressure: requests made while the model says busy are expected to be dropped.
module tb_sdp_ram_pipe;

  localparam int DW   = 32;
  localparam int DD   = 16;
  localparam int AW   = 4;
  localparam int NB   = DW / 8;
  localparam int NI   = 4;
  localparam int MAXC = 2048;
  localparam int BIG  = 1 << 30;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wea;
  logic [NB-1:0] wstrb;
  logic [AW-1:0] addra;
  logic [DW-1:0] dia;
  logic          reb;
  logic [AW-1:0] addrb;

  logic [DW-1:0] dob_o  [NI];
  logic          vld_o  [NI];
  logic          busy_o [NI];

  always #5 clk = ~clk;

  sdp_ram_pipe #(.DW(DW), .DD(DD), .RAM_TYPE("distributed"), .BYTE_EN(1), .RD_LATENCY(1),
                 .COLLISION("read_first"), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .resetn(resetn), .wea(wea), .wstrb(wstrb), .addra(addra), .dia(dia),
    .reb(reb), .addrb(addrb), .dob(dob_o[0]), .dob_valid(vld_o[0]), .init_busy(busy_o[0]));

  sdp_ram_pipe #(.DW(DW), .DD(DD), .RAM_TYPE("block"), .BYTE_EN(1), .RD_LATENCY(2),
                 .COLLISION("write_first"), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .wea(wea), .wstrb(wstrb), .addra(addra), .dia(dia),
    .reb(reb), .addrb(addrb), .dob(dob_o[1]), .dob_valid(vld_o[1]), .init_busy(busy_o[1]));

  sdp_ram_pipe #(.DW(DW), .DD(DD), .RAM_TYPE("ultra"), .BYTE_EN(1), .RD_LATENCY(3),
                 .COLLISION("read_first"), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .resetn(resetn), .wea(wea), .wstrb(wstrb), .addra(addra), .dia(dia),
    .reb(reb), .addrb(addrb), .dob(dob_o[2]), .dob_valid(vld_o[2]), .init_busy(busy_o[2]));

  sdp_ram_pipe #(.DW(DW), .DD(DD), .RAM_TYPE("block"), .BYTE_EN(1), .RD_LATENCY(1),
                 .COLLISION("write_first"), .CLEAR_ON_RESET(1)) u_dut3 (
    .clk(clk), .resetn(resetn), .wea(wea), .wstrb(wstrb), .addra(addra), .dia(dia),
    .reb(reb), .addrb(addrb), .dob(dob_o[3]), .dob_valid(vld_o[3]), .init_busy(busy_o[3]));

  // Reference model state
  logic [DW-1:0] mem_m  [DD];
  logic          exp_vld [MAXC];
  logic [DW-1:0] exp_rf  [MAXC];
  logic [DW-1:0] exp_wf  [MAXC];
  logic [DW-1:0] last_m  [NI];
  int            cyc;
  int            ready_cyc;
  logic          prev_rn;

  int n_chk;
  int n_pass;

  function automatic int lat_of(input int i);
    return (i == 0 || i == 3) ? 1 : ((i == 1) ? 2 : 3);
  endfunction

  function automatic logic wf_of(input int i);
    return (i == 1 || i == 3);
  endfunction

  function automatic logic [DW-1:0] overlay(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [NB-1:0] ws);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) begin
      if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
  endtask

  // One clock cycle: check outputs of the current cycle, then apply this cycle's inputs
  task automatic tick(input logic rn, input logic w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [NB-1:0] ws,
                      input logic r, input logic [AW-1:0] ra);
    int            is;
    logic          ev;
    logic [DW-1:0] ed;
    logic          acc;
    for (int i = 0; i < NI; i++) begin
      is = cyc - lat_of(i);
      ev = (is >= 0) ? exp_vld[is] : 1'b0;
      ed = (is < 0) ? '0 : (wf_of(i) ? exp_wf[is] : exp_rf[is]);
      chk($sformatf("busy%0d", i), {31'd0, busy_o[i]}, {31'd0, (cyc < ready_cyc)});
      chk($sformatf("valid%0d", i), {31'd0, vld_o[i]}, {31'd0, ev});
      if (ev) last_m[i] = ed;
      chk($sformatf("dob%0d", i), dob_o[i], last_m[i]);
    end

    resetn = rn; wea = w; addra = wa; dia = wd; wstrb = ws; reb = r; addrb = ra;

    acc = rn && (cyc >= ready_cyc);
    exp_vld[cyc] = 1'b0;
    if (acc && r) begin
      exp_vld[cyc] = 1'b1;
      exp_rf[cyc]  = mem_m[ra];
      exp_wf[cyc]  = (w && wa == ra) ? overlay(mem_m[ra], wd, ws) : mem_m[ra];
    end
    if (acc && w) mem_m[wa] = overlay(mem_m[wa], wd, ws);

    if (!rn) begin
      ready_cyc = BIG;
      for (int k = cyc - 3; k <= cyc; k++) if (k >= 0) exp_vld[k] = 1'b0;
      for (int i = 0; i < NI; i++) last_m[i] = '0;
    end else if (!prev_rn) begin
      ready_cyc = cyc + DD + 1;
      for (int a = 0; a < DD; a++) mem_m[a] = '0;
    end
    prev_rn = rn;

    @(posedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    tick(1'b1, 1'b1, a, d, s, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  task automatic in_reset(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic          w, r;
    logic [AW-1:0] wa, ra;

    n_chk = 0; n_pass = 0; cyc = 0; ready_cyc = BIG; prev_rn = 1'b0;
    for (int i = 0; i < NI; i++) last_m[i] = '0;
    for (int k = 0; k < MAXC; k++) exp_vld[k] = 1'b0;
    for (int a = 0; a < DD; a++) mem_m[a] = 'x;
    resetn = 1'b0; wea = 1'b0; wstrb = '0; addra = '0; dia = '0; reb = 1'b0; addrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state, then release and watch the DD+1 busy window
    in_reset(2);
    idle(DD + 3);

    // Freshly cleared array reads zero everywhere
    for (int a = 0; a < DD; a++) rd(AW'(a));
    idle(4);

    // Full write then single-byte patch
    wr(4'd3, 32'hAABBCCDD, 4'hF);
    wr(4'd3, 32'h00000011, 4'h1);
    rd(4'd3);
    idle(4);

    // Back-to-back reads of distinct words
    for (int a = 0; a < 4; a++) wr(AW'(a), 32'h1000_0000 + 32'(a * 32'h0101_0101 + 7), 4'hF);
    for (int a = 0; a < 4; a++) rd(AW'(a));
    idle(4);

    // Same-address collision
    wr(4'd5, 32'h1, 4'hF);
    tick(1'b1, 1'b1, 4'd5, 32'h2, 4'hF, 1'b1, 4'd5);
    idle(4);

    // Reads in flight when reset hits are dropped
    rd(4'd3);
    rd(4'd1);
    in_reset(2);

    // Release, abort at clear address 7, release again
    idle(8);
    in_reset(2);
    idle(11);
    // Requests while still clearing must be dropped
    tick(1'b1, 1'b1, 4'd2, 32'hDEADBEEF, 4'hF, 1'b1, 4'd2);
    idle(8);
    for (int a = 0; a < DD; a++) rd(AW'(a));
    idle(4);

    // Random traffic with frequent same-address collisions
    for (int k = 0; k < 400; k++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, DD - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DD - 1));
      tick(1'b1, w, wa, $urandom, NB'($urandom_range(0, 15)), r, ra);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
